// File: rtl/onehot_encoder_drain_if.sv
// onehot_encoder_drain_if: request-vector in / index-beat out handshake bundle
interface onehot_encoder_drain_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] d;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         last;
    logic         none;
    logic [W:0]   count;
    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, y, last, none, count
    );
    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, y, last, none, count
    );
endinterface

// File: rtl/onehot_encoder_drain.sv
// onehot_encoder_drain: emits the index of every set request bit, lowest first, one per beat
module onehot_encoder_drain #(
    parameter int N = 4,
    parameter int W = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    onehot_encoder_drain_if.slave  bus
);
    localparam logic [0:0]   IDLE  = 1'b0;
    localparam logic [0:0]   DRAIN = 1'b1;
    localparam logic [N-1:0] ONE   = N'(1);
    logic [0:0]   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         none_q, none_d;
    logic [W:0]   count_q, count_d;
    logic [W-1:0] lo;
    logic [W:0]   pop;
    logic         single, drain, last_c;
    always_comb begin
        lo = '0;
        for (int i = N - 1; i >= 0; i--) lo = pend_q[i] ? W'(i) : lo;
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + (W+1)'(bus.d[i]);
    end
    assign single = (pend_q != '0) && ((pend_q & (pend_q - ONE)) == '0);
    assign drain  = state_q == DRAIN;
    assign last_c = drain && (single || none_q);
    assign bus.in_ready  = !drain;
    assign bus.out_valid = drain;
    assign bus.y         = lo;
    assign bus.last      = last_c;
    assign bus.none      = none_q;
    assign bus.count     = count_q;
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;
        count_d = count_q;
        if (!drain && bus.in_valid) begin
            state_d = DRAIN;
            pend_d  = bus.d;
            none_d  = bus.d == '0;
            count_d = pop;
        end else if (drain && bus.out_ready) begin
            state_d = last_c ? IDLE : DRAIN;
            pend_d  = last_c ? '0 : pend_q & ~(ONE << lo);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            none_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            none_q  <= none_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_drain.sv
// tb_onehot_encoder_drain: scoreboard bench for the sequential priority encoder
module tb_onehot_encoder_drain;
    localparam int N = 4;
    localparam int W = 2;
    typedef struct packed {
        logic [W-1:0] y;
        logic         last;
        logic         none;
        logic [W:0]   count;
    } beat_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    beat_t q[$];
    onehot_encoder_drain_if #(.N(N), .W(W)) bus ();
    onehot_encoder_drain #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // model: one beat per set bit ascending, or a single none beat for a zero vector
    task automatic push_exp(input logic [N-1:0] v);
        int k;
        int seen;
        beat_t b;
        k = $countones(v);
        seen = 0;
        if (k == 0) begin
            b = '{y: '0, last: 1'b1, none: 1'b1, count: '0};
            q.push_back(b);
        end
        for (int i = 0; i < N; i++) if (v[i]) begin
            seen++;
            b = '{y: W'(i), last: seen == k, none: 1'b0, count: (W+1)'(k)};
            q.push_back(b);
        end
    endtask
    always @(negedge clk) if (rst_n && bus.out_valid) begin
        if (q.size() == 0) chk("spurious_beat", bus.out_valid, 1'b0);
        else begin
            chk("y", bus.y, q[0].y);
            chk("last", bus.last, q[0].last);
            chk("none", bus.none, q[0].none);
            chk("count", bus.count, q[0].count);
            if (bus.out_ready) void'(q.pop_front());
        end
    end
    // holds the vector from the current point until the next accept edge
    task automatic send(input logic [N-1:0] v);
        int t;
        push_exp(v);
        bus.in_valid = 1'b1;
        bus.d = v;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) chk("accept_timeout", t, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("latency_out_valid", bus.out_valid, 1'b1);
    endtask
    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0 || !bus.in_ready) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", q.size(), 0);
        chk("idle_in_ready", bus.in_ready, 1'b1);
    endtask
    task automatic busy_cycles(input int exp);
        int t;
        t = 1;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            if (!bus.in_ready) t++;
        end
        chk("in_ready_low_cycles", t, exp);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.d = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_y", bus.y, 0);
        chk("rst_last", bus.last, 1'b0);
        chk("rst_none", bus.none, 1'b0);
        chk("rst_count", bus.count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0100);
        busy_cycles(1);
        wait_idle();
        send(4'b1011);
        busy_cycles(3);
        wait_idle();
        bus.out_ready = 1'b0;
        send(4'b0110);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_hold_y", bus.y, 1);
            chk("stall_hold_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        wait_idle();
        send(4'b0000);
        busy_cycles(1);
        wait_idle();
        send(4'b1100);
        send(4'b0001);
        wait_idle();
        send(4'b1111);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_pending_left", q.size(), 2);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", bus.out_valid, 1'b0);
        send(4'b1000);
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
